// File: rtl/hdc_am_pkg.sv
// hdc_am_pkg: search state type and width helpers for the folded AM search.
package hdc_am_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} am_state_t;
    localparam int DEF_HV_DIMENSION = 2000;
    localparam int DEF_AM_NUM_FOLDS = 50;
    function automatic int fold_width(input int hv, input int n);
        return hv / n;
    endfunction
    function automatic int dist_width(input int hv);
        return $clog2(hv + 1);
    endfunction
    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/am_dist_accum.sv
// am_dist_accum: clearable running sum of one prototype's partial distances.
module am_dist_accum #(
    parameter int PDIST_WIDTH = 6,
    parameter int DIST_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [PDIST_WIDTH-1:0] pdist,
    output logic [DIST_WIDTH-1:0]  total
);
    logic [DIST_WIDTH-1:0] acc;
    assign total = acc + (en ? DIST_WIDTH'(pdist) : '0);
    always_ff @(posedge clk)
        if (rst || clr) acc <= '0;
        else acc <= total;
endmodule

// File: rtl/am_fold_controller.sv
// am_fold_controller: steps the AM fold index, sums per-prototype distances, emits labels.
module am_fold_controller
    import hdc_am_pkg::*;
#(
    parameter int AM_NUM_FOLDS = DEF_AM_NUM_FOLDS,
    parameter int HV_DIMENSION = DEF_HV_DIMENSION,
    localparam int FOLD_WIDTH = fold_width(HV_DIMENSION, AM_NUM_FOLDS),
    localparam int PDIST_WIDTH = $clog2(FOLD_WIDTH + 1),
    localparam int DIST_WIDTH = dist_width(HV_DIMENSION),
    localparam int IDX_WIDTH = idx_width(AM_NUM_FOLDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   qry_valid,
    output logic                   qry_ready,
    output logic                   qry_done,
    output logic                   fold_en,
    output logic [IDX_WIDTH-1:0]   fold_idx,
    input  logic [PDIST_WIDTH-1:0] pdist_v0,
    input  logic [PDIST_WIDTH-1:0] pdist_v1,
    input  logic [PDIST_WIDTH-1:0] pdist_a0,
    input  logic [PDIST_WIDTH-1:0] pdist_a1,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   valence,
    output logic                   arousal
);
    am_state_t state, state_nxt;
    logic [IDX_WIDTH-1:0] fold_idx_nxt;
    logic acc_en, clr, last;
    logic [DIST_WIDTH-1:0] tot_v0, tot_v1, tot_a0, tot_a1;

    assign qry_ready = state == IDLE;
    assign fold_en = state == ISSUE;
    assign dout_valid = state == DONE;
    assign last = fold_idx == IDX_WIDTH'(AM_NUM_FOLDS - 1);

    always_comb begin
        state_nxt = state;
        fold_idx_nxt = fold_idx;
        clr = 1'b0;
        case (state)
            IDLE: if (qry_valid) begin
                clr = 1'b1;
                fold_idx_nxt = '0;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                fold_idx_nxt = last ? '0 : fold_idx + 1'b1;
                state_nxt = last ? DRAIN : ISSUE;
            end
            DRAIN: state_nxt = DONE;
            DONE: if (dout_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // labels compare the totals including the last fold absorbed on this same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fold_idx <= '0;
            acc_en <= 1'b0;
            qry_done <= 1'b0;
            valence <= 1'b0;
            arousal <= 1'b0;
        end else begin
            state <= state_nxt;
            fold_idx <= fold_idx_nxt;
            acc_en <= fold_en;
            qry_done <= state == DRAIN;
            if (state == DRAIN) begin
                valence <= tot_v1 < tot_v0;
                arousal <= tot_a1 < tot_a0;
            end
        end
    end

    am_dist_accum #(.PDIST_WIDTH(PDIST_WIDTH), .DIST_WIDTH(DIST_WIDTH)) u_v0 (
        .clk(clk), .rst(rst), .clr(clr), .en(acc_en), .pdist(pdist_v0), .total(tot_v0));
    am_dist_accum #(.PDIST_WIDTH(PDIST_WIDTH), .DIST_WIDTH(DIST_WIDTH)) u_v1 (
        .clk(clk), .rst(rst), .clr(clr), .en(acc_en), .pdist(pdist_v1), .total(tot_v1));
    am_dist_accum #(.PDIST_WIDTH(PDIST_WIDTH), .DIST_WIDTH(DIST_WIDTH)) u_a0 (
        .clk(clk), .rst(rst), .clr(clr), .en(acc_en), .pdist(pdist_a0), .total(tot_a0));
    am_dist_accum #(.PDIST_WIDTH(PDIST_WIDTH), .DIST_WIDTH(DIST_WIDTH)) u_a1 (
        .clk(clk), .rst(rst), .clr(clr), .en(acc_en), .pdist(pdist_a1), .total(tot_a1));
endmodule

// File: tb/tb_am_fold_controller.sv
// tb_am_fold_controller: scoreboard bench for the folded AM search controller (N=50 and N=1).
module tb_am_fold_controller;
    localparam int N = 50;
    localparam int HV = 2000;
    localparam int PW = $clog2(HV / N + 1);
    localparam int DW = $clog2(HV + 1);
    localparam int IW = $clog2(N);
    localparam int PW1 = $clog2(HV + 1);

    typedef struct {
        logic val;
        logic aro;
        int   acc_cyc;
    } exp_t;

    logic clk = 0, rst = 1, qry_valid = 0, dout_ready = 1;
    logic qry_ready, qry_done, fold_en, dout_valid, valence, arousal;
    logic [IW-1:0] fold_idx;
    logic [PW-1:0] pdist_v0 = '0, pdist_v1 = '0, pdist_a0 = '0, pdist_a1 = '0;
    logic qv1 = 0, dr1 = 1;
    logic qr1, qd1, fe1, dv1, val1, aro1;
    logic [0:0] fi1;
    logic [PW1-1:0] pv0 = '0, pv1 = '0, pa0 = '0, pa1 = '0;

    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0;
    int pat[4] = '{0, 0, 0, 0};
    int nxt[4] = '{0, 0, 0, 0};
    int win_lo = -1, win_hi = -1;

    am_fold_controller #(.AM_NUM_FOLDS(N), .HV_DIMENSION(HV)) dut (
        .clk(clk), .rst(rst), .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_done(qry_done),
        .fold_en(fold_en), .fold_idx(fold_idx), .pdist_v0(pdist_v0), .pdist_v1(pdist_v1),
        .pdist_a0(pdist_a0), .pdist_a1(pdist_a1), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .valence(valence), .arousal(arousal));

    am_fold_controller #(.AM_NUM_FOLDS(1), .HV_DIMENSION(HV)) dut1 (
        .clk(clk), .rst(rst), .qry_valid(qv1), .qry_ready(qr1), .qry_done(qd1),
        .fold_en(fe1), .fold_idx(fi1), .pdist_v0(pv0), .pdist_v1(pv1),
        .pdist_a0(pa0), .pdist_a1(pa1), .dout_valid(dv1), .dout_ready(dr1),
        .valence(val1), .arousal(aro1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // an accept seen before the edge schedules the pdist window and the expected labels
    task automatic tick();
        bit w;
        if (qry_valid && qry_ready && !rst) begin
            pat = nxt;
            win_lo = cyc + 2;
            win_hi = cyc + N + 1;
            sb.push_back('{nxt[1] < nxt[0], nxt[3] < nxt[2], cyc});
        end
        @(posedge clk);
        #1;
        w = cyc >= win_lo && cyc <= win_hi;
        pdist_v0 = w ? PW'(pat[0]) : PW'($urandom);
        pdist_v1 = w ? PW'(pat[1]) : PW'($urandom);
        pdist_a0 = w ? PW'(pat[2]) : PW'($urandom);
        pdist_a1 = w ? PW'(pat[3]) : PW'($urandom);
    endtask

    task automatic launch();
        qry_valid = 1;
        tick();
        qry_valid = 0;
    endtask

    task automatic wait_dv(output bit ok);
        for (int i = 0; i < 200 && !dout_valid; i++) tick();
        ok = dout_valid;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{1'bx, 1'bx, -1};
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        checks++;
        if ({qry_ready, fold_en, qry_done, dout_valid, valence, arousal} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 100000", {qry_ready, fold_en, qry_done, dout_valid, valence, arousal});
        end
        checks++;
        if (fold_idx !== '0) begin
            errors++;
            $display("FAIL reset_fold_idx got %0d want 0", fold_idx);
        end
        checks++;
        if ({qr1, fe1, qd1, dv1, val1, aro1, fi1} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_n1 got %b want 1000000", {qr1, fe1, qd1, dv1, val1, aro1, fi1});
        end
        checks++;
        if ({dut.u_v0.acc, dut.u_v1.acc, dut.u_a0.acc, dut.u_a1.acc} !== '0) begin
            errors++;
            $display("FAIL reset_acc got %h want 0", {dut.u_v0.acc, dut.u_v1.acc, dut.u_a0.acc, dut.u_a1.acc});
        end
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        exp_t e;
        int idx = 0, first = -1;
        bit seq_ok = 1;
        nxt = '{3, 2, 1, 4};
        launch();
        for (int i = 0; i < 200 && !dout_valid; i++) begin
            if (fold_en) begin
                if (first < 0) first = cyc;
                if (fold_idx !== IW'(idx)) seq_ok = 0;
                idx++;
            end else if (idx != 0 && idx != N) seq_ok = 0;
            tick();
        end
        pop_exp(e);
        checks++;
        if (dout_valid !== 1'b1 || cyc - e.acc_cyc != N + 2) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d (valid=%b)", cyc - e.acc_cyc, N + 2, dout_valid);
        end
        checks++;
        if (!seq_ok || idx != N || first != e.acc_cyc + 1) begin
            errors++;
            $display("FAIL basic_fold_seq got folds=%0d first=%0d contiguous=%0d want folds=%0d first=%0d contiguous=1",
                     idx, first, seq_ok, N, e.acc_cyc + 1);
        end
        checks++;
        if ({valence, arousal} !== {e.val, e.aro}) begin
            errors++;
            $display("FAIL basic_labels got %b want %b", {valence, arousal}, {e.val, e.aro});
        end
        checks++;
        if ({dut.u_v0.acc, dut.u_v1.acc, dut.u_a0.acc, dut.u_a1.acc} !==
            {DW'(pat[0] * N), DW'(pat[1] * N), DW'(pat[2] * N), DW'(pat[3] * N)}) begin
            errors++;
            $display("FAIL basic_acc got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     dut.u_v0.acc, dut.u_v1.acc, dut.u_a0.acc, dut.u_a1.acc,
                     pat[0] * N, pat[1] * N, pat[2] * N, pat[3] * N);
        end
        checks++;
        if (qry_done !== 1'b1 || qry_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b ready=%b want done=1 ready=0", qry_done, qry_ready);
        end
        tick();
        checks++;
        if ({qry_done, dout_valid, qry_ready} !== 3'b001) begin
            errors++;
            $display("FAIL basic_after_handshake got %b want 001", {qry_done, dout_valid, qry_ready});
        end
    endtask

    task automatic test_tie();
        exp_t e;
        bit ok;
        nxt = '{5, 5, 5, 5};
        launch();
        wait_dv(ok);
        pop_exp(e);
        checks++;
        if (!ok || {valence, arousal} !== {e.val, e.aro}) begin
            errors++;
            $display("FAIL tie_labels got %b (valid=%b) want %b", {valence, arousal}, ok, {e.val, e.aro});
        end
        checks++;
        if ({valence, arousal} !== 2'b00) begin
            errors++;
            $display("FAIL tie_zero got %b want 00", {valence, arousal});
        end
        tick();
    endtask

    task automatic test_back_pressure();
        exp_t e;
        bit ok, bad = 0;
        logic [1:0] lab;
        nxt = '{7, 9, 2, 1};
        dout_ready = 0;
        qry_valid = 1;
        tick();
        wait_dv(ok);
        pop_exp(e);
        checks++;
        if (!ok || {valence, arousal} !== {e.val, e.aro}) begin
            errors++;
            $display("FAIL bp_labels got %b (valid=%b) want %b", {valence, arousal}, ok, {e.val, e.aro});
        end
        lab = {valence, arousal};
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({valence, arousal} !== lab || {dout_valid, qry_ready, fold_en, qry_done} !== 4'b1000) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold got labels=%b v/r/en/done=%b want labels=%b v/r/en/done=1000",
                     {valence, arousal}, {dout_valid, qry_ready, fold_en, qry_done}, lab);
        end
        qry_valid = 0;
        dout_ready = 1;
        tick();
        checks++;
        if ({qry_ready, dout_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got ready/valid=%b want 10", {qry_ready, dout_valid});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit ok;
        int prev = -1;
        dout_ready = 1;
        for (int j = 0; j < 4; j++) nxt[j] = $urandom_range(0, 40);
        qry_valid = 1;
        for (int q = 0; q < 20; q++) begin
            for (int i = 0; i < 100 && !qry_ready; i++) tick();
            tick();
            if (q == 19) qry_valid = 0;
            for (int j = 0; j < 4; j++) nxt[j] = $urandom_range(0, 40);
            wait_dv(ok);
            pop_exp(e);
            checks++;
            if (!ok || {valence, arousal} !== {e.val, e.aro}) begin
                errors++;
                $display("FAIL b2b_labels q%0d got %b (valid=%b) want %b", q, {valence, arousal}, ok, {e.val, e.aro});
            end
            if (q > 0) begin
                checks++;
                if (e.acc_cyc - prev != N + 3) begin
                    errors++;
                    $display("FAIL b2b_spacing q%0d got %0d want %0d", q, e.acc_cyc - prev, N + 3);
                end
            end
            prev = e.acc_cyc;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit ok;
        nxt = '{0, 40, 40, 0};
        launch();
        for (int i = 0; i < 100 && !(fold_en && fold_idx == IW'(17)); i++) tick();
        checks++;
        if (!(fold_en && fold_idx == IW'(17))) begin
            errors++;
            $display("FAIL rmid_reach got en=%b idx=%0d want en=1 idx=17", fold_en, fold_idx);
        end
        rst = 1;
        tick();
        checks++;
        if ({qry_ready, fold_en, qry_done, dout_valid, valence, arousal} !== 6'b100000 || fold_idx !== '0) begin
            errors++;
            $display("FAIL rmid_outputs got %b idx=%0d want 100000 idx=0",
                     {qry_ready, fold_en, qry_done, dout_valid, valence, arousal}, fold_idx);
        end
        checks++;
        if ({dut.u_v0.acc, dut.u_v1.acc, dut.u_a0.acc, dut.u_a1.acc} !== '0) begin
            errors++;
            $display("FAIL rmid_acc got %h want 0", {dut.u_v0.acc, dut.u_v1.acc, dut.u_a0.acc, dut.u_a1.acc});
        end
        sb.delete();
        win_hi = -1;
        rst = 0;
        nxt = '{2, 1, 1, 2};
        launch();
        wait_dv(ok);
        pop_exp(e);
        checks++;
        if (!ok || {valence, arousal} !== {e.val, e.aro}) begin
            errors++;
            $display("FAIL rmid_fresh got %b (valid=%b) want %b", {valence, arousal}, ok, {e.val, e.aro});
        end
        tick();
    endtask

    task automatic test_single_fold();
        int k;
        logic [1:0] want;
        pv0 = 1000;
        pv1 = 999;
        pa0 = 5;
        pa1 = 5;
        want = {pv1 < pv0, pa1 < pa0};
        dr1 = 1;
        qv1 = 1;
        k = cyc;
        checks++;
        if (qr1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_ready got %b want 1", qr1);
        end
        tick();
        qv1 = 0;
        checks++;
        if ({fe1, fi1} !== 2'b10) begin
            errors++;
            $display("FAIL n1_issue got en/idx=%b want 10", {fe1, fi1});
        end
        for (int i = 0; i < 10 && !dv1; i++) tick();
        checks++;
        if (dv1 !== 1'b1 || cyc - k != 3) begin
            errors++;
            $display("FAIL n1_latency got %0d (valid=%b) want 3", cyc - k, dv1);
        end
        checks++;
        if ({val1, aro1} !== want) begin
            errors++;
            $display("FAIL n1_labels got %b want %b", {val1, aro1}, want);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        test_single_fold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
